// File: rtl/fft_pkg.sv
// Shared constants for the FFT datapath blocks.
//   N_DEFAULT    : default real/imag sample width (two's complement)
//   Q_DEFAULT    : default twiddle fractional bits (1.0 = 2^Q)
//   BFLY_LATENCY : input-to-output latency of dit_butterfly in cycles
//   SAT_MAX/MIN  : saturation limits for the default sample width
package fft_pkg;
    localparam int N_DEFAULT    = 16;
    localparam int Q_DEFAULT    = 14;
    localparam int BFLY_LATENCY = 4;
    localparam int SAT_MAX      = (1 << (N_DEFAULT - 1)) - 1;
    localparam int SAT_MIN      = -(1 << (N_DEFAULT - 1));
endpackage

// File: rtl/dit_butterfly_cmul_q.sv
// cmul_q: pipelined complex multiply P = B * W in Q-format.
// Stage 2 forms the four real products (truncated toward zero by Q bits,
// saturated to N bits); stage 3 combines them into the real/imag parts at
// N+1 bits and saturates back to N bits.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   en              : pipeline advance enable
//   in_valid        : valid bit of the operands presented this cycle
//   b_re..w_im      : multiplicand B and twiddle W
//   out_valid       : valid bit aligned with p_re/p_im
//   p_re, p_im      : registered product
//   sat_evt         : a valid beat saturated while advancing this cycle
module cmul_q
    import fft_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int Q = Q_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    input  logic [N-1:0] b_re,
    input  logic [N-1:0] b_im,
    input  logic [N-1:0] w_re,
    input  logic [N-1:0] w_im,
    output logic         out_valid,
    output logic [N-1:0] p_re,
    output logic [N-1:0] p_im,
    output logic         sat_evt
);

    // Returns {saturated_flag, value clamped to N bits}. The value fits when
    // all bits from the N-bit sign position upward agree.
    function automatic logic [N:0] sat_n(input logic [2*N-1:0] v);
        logic fits;
        fits = (&v[2*N-1:N-1]) | ~(|v[2*N-1:N-1]);
        if (fits) return {1'b0, v[N-1:0]};
        else      return {1'b1, v[2*N-1], {(N-1){~v[2*N-1]}}};
    endfunction

    // Negative products get a 2^Q-1 bias before the arithmetic shift so the
    // shift rounds toward zero instead of toward minus infinity.
    function automatic logic [N:0] mul_trunc(input logic [N-1:0] x, input logic [N-1:0] y);
        logic signed [2*N-1:0] p;
        logic signed [2*N-1:0] bias;
        logic signed [2*N-1:0] t;
        p    = $signed(x) * $signed(y);
        bias = '0;
        if (p[2*N-1]) bias[Q-1:0] = '1;
        t    = (p + bias) >>> Q;
        return sat_n(t);
    endfunction

    logic [N:0]   m_rr, m_ii, m_ri, m_ir;
    logic [N-1:0] rr, ii, ri, ir;
    logic         v2;
    logic signed [N:0] s_re, s_im;
    logic [N:0]   c_re, c_im;

    always_comb begin
        m_rr = mul_trunc(b_re, w_re);
        m_ii = mul_trunc(b_im, w_im);
        m_ri = mul_trunc(b_re, w_im);
        m_ir = mul_trunc(b_im, w_re);
    end

    always_comb begin
        s_re = $signed({rr[N-1], rr}) - $signed({ii[N-1], ii});
        s_im = $signed({ri[N-1], ri}) + $signed({ir[N-1], ir});
        c_re = sat_n({{(N-1){s_re[N]}}, s_re});
        c_im = sat_n({{(N-1){s_im[N]}}, s_im});
    end

    assign sat_evt = en & ((in_valid & (m_rr[N] | m_ii[N] | m_ri[N] | m_ir[N]))
                         | (v2 & (c_re[N] | c_im[N])));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr        <= '0;
            ii        <= '0;
            ri        <= '0;
            ir        <= '0;
            v2        <= 1'b0;
            p_re      <= '0;
            p_im      <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            rr        <= m_rr[N-1:0];
            ii        <= m_ii[N-1:0];
            ri        <= m_ri[N-1:0];
            ir        <= m_ir[N-1:0];
            v2        <= in_valid;
            p_re      <= c_re[N-1:0];
            p_im      <= c_im[N-1:0];
            out_valid <= v2;
        end
    end

endmodule

// File: rtl/dit_butterfly.sv
// dit_butterfly: radix-2 decimation-in-time butterfly, 4-stage pipeline.
//   X = A + B*W, Y = A - B*W, optionally halved (scale), saturated to N bits.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : input handshake (in_ready = global enable)
//   a_*, b_*, w_*       : operands A, B and twiddle W (Q fractional bits)
//   scale               : halve both outputs, sampled with the operands
//   out_valid, out_ready: output handshake
//   x_*, y_*            : butterfly outputs
//   ovf, ovf_clr        : sticky saturation flag and its synchronous clear
module dit_butterfly
    import fft_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int Q = Q_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_re,
    input  logic [N-1:0] a_im,
    input  logic [N-1:0] b_re,
    input  logic [N-1:0] b_im,
    input  logic [N-1:0] w_re,
    input  logic [N-1:0] w_im,
    input  logic         scale,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] x_re,
    output logic [N-1:0] x_im,
    output logic [N-1:0] y_re,
    output logic [N-1:0] y_im,
    output logic         ovf,
    input  logic         ovf_clr
);

    function automatic logic [N:0] sat_n(input logic [2*N-1:0] v);
        logic fits;
        fits = (&v[2*N-1:N-1]) | ~(|v[2*N-1:N-1]);
        if (fits) return {1'b0, v[N-1:0]};
        else      return {1'b1, v[2*N-1], {(N-1){~v[2*N-1]}}};
    endfunction

    logic         en;
    logic         v1, v3;
    logic [N-1:0] a1_re, a1_im, b1_re, b1_im, w1_re, w1_im;
    logic [N-1:0] a2_re, a2_im, a3_re, a3_im;
    logic         sc1, sc2, sc3;
    logic [N-1:0] p_re, p_im;
    logic         cm_evt;
    logic signed [N:0] sx_re, sx_im, sy_re, sy_im;
    logic [N:0]   cx_re, cx_im, cy_re, cy_im;
    logic         s4_evt;

    // Whole pipeline stalls together; bubbles are held, not collapsed.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    cmul_q #(.N(N), .Q(Q)) u_cmul (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (v1),
        .b_re      (b1_re),
        .b_im      (b1_im),
        .w_re      (w1_re),
        .w_im      (w1_im),
        .out_valid (v3),
        .p_re      (p_re),
        .p_im      (p_im),
        .sat_evt   (cm_evt)
    );

    always_comb begin
        sx_re = $signed({a3_re[N-1], a3_re}) + $signed({p_re[N-1], p_re});
        sx_im = $signed({a3_im[N-1], a3_im}) + $signed({p_im[N-1], p_im});
        sy_re = $signed({a3_re[N-1], a3_re}) - $signed({p_re[N-1], p_re});
        sy_im = $signed({a3_im[N-1], a3_im}) - $signed({p_im[N-1], p_im});
        if (sc3) begin
            sx_re = sx_re >>> 1;
            sx_im = sx_im >>> 1;
            sy_re = sy_re >>> 1;
            sy_im = sy_im >>> 1;
        end
        cx_re  = sat_n({{(N-1){sx_re[N]}}, sx_re});
        cx_im  = sat_n({{(N-1){sx_im[N]}}, sx_im});
        cy_re  = sat_n({{(N-1){sy_re[N]}}, sy_re});
        cy_im  = sat_n({{(N-1){sy_im[N]}}, sy_im});
        s4_evt = en & v3 & (cx_re[N] | cx_im[N] | cy_re[N] | cy_im[N]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            a1_re     <= '0;
            a1_im     <= '0;
            b1_re     <= '0;
            b1_im     <= '0;
            w1_re     <= '0;
            w1_im     <= '0;
            sc1       <= 1'b0;
            a2_re     <= '0;
            a2_im     <= '0;
            sc2       <= 1'b0;
            a3_re     <= '0;
            a3_im     <= '0;
            sc3       <= 1'b0;
            out_valid <= 1'b0;
            x_re      <= '0;
            x_im      <= '0;
            y_re      <= '0;
            y_im      <= '0;
        end else if (en) begin
            v1        <= in_valid;
            a1_re     <= a_re;
            a1_im     <= a_im;
            b1_re     <= b_re;
            b1_im     <= b_im;
            w1_re     <= w_re;
            w1_im     <= w_im;
            sc1       <= scale;
            a2_re     <= a1_re;
            a2_im     <= a1_im;
            sc2       <= sc1;
            a3_re     <= a2_re;
            a3_im     <= a2_im;
            sc3       <= sc2;
            out_valid <= v3;
            x_re      <= cx_re[N-1:0];
            x_im      <= cx_im[N-1:0];
            y_re      <= cy_re[N-1:0];
            y_im      <= cy_im[N-1:0];
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    ovf <= 1'b0;
        else if (cm_evt || s4_evt)  ovf <= 1'b1;
        else if (ovf_clr)           ovf <= 1'b0;
    end

endmodule

// File: tb/tb_dit_butterfly.sv
module tb_dit_butterfly;
    import fft_pkg::*;

    localparam int N = 16;
    localparam int Q = 14;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic         scale;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] x_re, x_im, y_re, y_im;
    logic         ovf;
    logic         ovf_clr;

    dit_butterfly #(.N(N), .Q(Q)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .scale     (scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_re      (x_re),
        .x_im      (x_im),
        .y_re      (y_re),
        .y_im      (y_im),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int xr;
        int xi;
        int yr;
        int yi;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference model: integer division truncates toward zero.
    function automatic int sat(input longint v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return int'(v);
    endfunction

    function automatic int tprod(input int b, input int w);
        longint p;
        p = longint'(b) * longint'(w);
        return sat(p / (longint'(1) << Q));
    endfunction

    function automatic exp_t mdl(input int ar, input int ai, input int br, input int bi,
                                 input int wr, input int wi, input bit sc);
        exp_t   e;
        longint tr, ti, xr, xi, yr, yi;
        tr = sat(longint'(tprod(br, wr)) - longint'(tprod(bi, wi)));
        ti = sat(longint'(tprod(br, wi)) + longint'(tprod(bi, wr)));
        xr = ar + tr;
        xi = ai + ti;
        yr = ar - tr;
        yi = ai - ti;
        if (sc) begin
            xr = xr >>> 1;
            xi = xi >>> 1;
            yr = yr >>> 1;
            yi = yi >>> 1;
        end
        e.xr = sat(xr);
        e.xi = sat(xi);
        e.yr = sat(yr);
        e.yi = sat(yi);
        return e;
    endfunction

    function automatic exp_t mk(input int xr, input int xi, input int yr, input int yi);
        exp_t e;
        e.xr = xr; e.xi = xi; e.yr = yr; e.yi = yi;
        return e;
    endfunction

    // Output monitor: every output transfer pops one expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_result observed x_re=%0d expected no output", $signed(x_re));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("x_re", $signed(x_re), e.xr);
                check("x_im", $signed(x_im), e.xi);
                check("y_re", $signed(y_re), e.yr);
                check("y_im", $signed(y_im), e.yi);
            end
        end
    end

    // One cycle: drive just after the rising edge, report acceptance at the falling edge.
    task automatic step(input bit iv, input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi, input bit sc, input bit ordy, output bit acc);
        @(posedge clk);
        #1;
        in_valid  = iv;
        a_re      = ar[N-1:0];
        a_im      = ai[N-1:0];
        b_re      = br[N-1:0];
        b_im      = bi[N-1:0];
        w_re      = wr[N-1:0];
        w_im      = wi[N-1:0];
        scale     = sc;
        out_ready = ordy;
        @(negedge clk);
        acc = iv && in_ready;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, acc);
    endtask

    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi, input bit sc, input exp_t e);
        bit acc;
        int tries;
        acc   = 0;
        tries = 0;
        while (!acc && tries < 20) begin
            step(1, ar, ai, br, bi, wr, wi, sc, 1, acc);
            tries++;
        end
        if (acc) sb.push_back(e);
        vectors++;
        assert (acc) else begin
            miscompares++;
            $error("FAIL send_timeout observed in_ready=%0b expected 1", in_ready);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    initial begin
        bit   acc;
        exp_t e;
        int   ops[6][6];
        int   sent, cyc, stall_left;
        bit   started, ordy;

        rst = 1'b1; in_valid = 0; scale = 0; out_ready = 1; ovf_clr = 0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_x_re", $signed(x_re), 0);
        check("rst_y_im", $signed(y_im), 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Identity twiddle, with exact latency check
        send(1000, 200, 300, -100, 16384, 0, 0, mk(1300, 100, 700, 300));
        for (int k = 1; k <= BFLY_LATENCY; k++) begin
            idle(1);
            check($sformatf("latency_c%0d", k), out_valid, (k == BFLY_LATENCY) ? 1 : 0);
        end
        drain();

        // W = -j, truncation toward zero, back to back
        send(1000, 200, 300, -100, 0, -16384, 0, mk(900, -100, 1100, 500));
        send(0, 0, -3, 0, 16383, 0, 0, mk(-2, 0, 2, 0));
        idle(1);
        drain();
        check("ovf_clean", ovf, 0);

        // Saturation sets sticky ovf
        send(30000, 0, 10000, 0, 16384, 0, 0, mk(32767, 0, 20000, 0));
        idle(1);
        drain();
        check("ovf_set", ovf, 1);
        idle(3);
        check("ovf_sticky", ovf, 1);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_cleared", ovf, 0);

        // Same operands halved: no saturation
        send(30000, 0, 10000, 0, 16384, 0, 1, mk(20000, 0, 10000, 0));
        idle(1);
        drain();
        check("ovf_scaled", ovf, 0);

        // Random operands against the model
        for (int i = 0; i < 8; i++) begin
            int ar, ai, br, bi, wr, wi;
            bit sc;
            ar = int'($urandom_range(0, 65535)) - 32768;
            ai = int'($urandom_range(0, 65535)) - 32768;
            br = int'($urandom_range(0, 65535)) - 32768;
            bi = int'($urandom_range(0, 65535)) - 32768;
            wr = int'($urandom_range(0, 65535)) - 32768;
            wi = int'($urandom_range(0, 65535)) - 32768;
            sc = 1'($urandom_range(0, 1));
            send(ar, ai, br, bi, wr, wi, sc, mdl(ar, ai, br, bi, wr, wi, sc));
        end
        idle(1);
        drain();

        // Backpressure: 6 back-to-back beats, 3-cycle stall after first out_valid
        for (int i = 0; i < 6; i++) begin
            ops[i][0] = 100 * (i + 1);
            ops[i][1] = -50 * i;
            ops[i][2] = 7 * i - 20;
            ops[i][3] = 300 - 40 * i;
            ops[i][4] = 16384 - 1000 * i;
            ops[i][5] = 500 * i - 2000;
        end
        sent = 0; cyc = 0; stall_left = 0; started = 0;
        while ((sent < 6 || sb.size() != 0) && cyc < 60) begin
            ordy = (stall_left == 0);
            if (sent < 6)
                step(1, ops[sent][0], ops[sent][1], ops[sent][2], ops[sent][3],
                     ops[sent][4], ops[sent][5], 0, ordy, acc);
            else
                step(0, 0, 0, 0, 0, 0, 0, 0, ordy, acc);
            if (acc) begin
                sb.push_back(mdl(ops[sent][0], ops[sent][1], ops[sent][2], ops[sent][3],
                                 ops[sent][4], ops[sent][5], 0));
                sent++;
            end
            if (!ordy) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                check("stall_x_re", $signed(x_re), sb[0].xr);
                check("stall_y_im", $signed(y_im), sb[0].yi);
                stall_left--;
            end
            if (!started && out_valid) begin
                started    = 1;
                stall_left = 3;
            end
            cyc++;
        end
        check("bp_all_sent", sent, 6);
        drain();

        // Reset mid-stream with a held result at the output
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            step(1, 1234, -77, 500, 600, 16000, -3000, 0, 0, acc);
            if (acc) sb.push_back(mdl(1234, -77, 500, 600, 16000, -3000, 0));
            cyc++;
        end
        check("midrst_out_valid_before", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_x_re", $signed(x_re), 0);
        check("midrst_x_im", $signed(x_im), 0);
        check("midrst_y_re", $signed(y_re), 0);
        sb.delete();
        in_valid = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        idle(10);
        check("midrst_no_stale", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
